// File: rtl/icache_valid_array.sv
// icache_valid_array: valid-bit store for the instruction cache.
// NUM_SETS x NUM_WAYS flops with a one-hot decoded single-bit write port,
// a registered read port that also reports the lowest-index free way for
// refill victim choice, and a flash-invalidate engine that clears one set
// per cycle.
//
// Optional build macro ICACHE_VALID_BYPASS_EN: when defined, a read and a
// write to the same set at the same edge (in IDLE) return the post-write
// vector. When undefined, the same-set read returns the pre-write vector.
module icache_valid_array #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SET_W-1:0]    wr_set,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic                wr_val,
  input  logic                rd_en,
  input  logic [SET_W-1:0]    rd_set,
  output logic                rd_vld,
  output logic [NUM_WAYS-1:0] rd_valid,
  output logic                rd_free_vld,
  output logic [WAY_W-1:0]    rd_free_way,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                             state;
  logic [SET_W-1:0]                   sweep_cnt;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  vbits;

  logic                               wr_ok_p0;
  logic                               sweep_clr_p0;
  logic [NUM_SETS-1:0]                set_dec_p0;
  logic [NUM_WAYS-1:0]                way_dec_p0;
  logic [NUM_SETS-1:0]                sweep_dec_p0;
  logic [NUM_WAYS-1:0]                rd_row_p0;

  // Lowest-index invalid way; 0 when every way is valid.
  function automatic logic [WAY_W-1:0] first_free(input logic [NUM_WAYS-1:0] v);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!v[i]) idx = WAY_W'(i);
    end
    return idx;
  endfunction

  // Stage p0: write qualification and one-hot decodes for write and sweep.
  always_comb begin
    wr_ok_p0     = wr_en && (state == IDLE);
    sweep_clr_p0 = (state == SWEEP);
    set_dec_p0   = '0;
    set_dec_p0[wr_set] = 1'b1;
    way_dec_p0   = '0;
    way_dec_p0[wr_way] = 1'b1;
    sweep_dec_p0 = '0;
    sweep_dec_p0[sweep_cnt] = 1'b1;
  end

  // Array update: the sweep clear owns its set; otherwise one decoded bit takes wr_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbits <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (sweep_clr_p0 && sweep_dec_p0[s]) begin
            vbits[s][w] <= 1'b0;
          end else if (wr_ok_p0 && set_dec_p0[s] && way_dec_p0[w]) begin
            vbits[s][w] <= wr_val;
          end
        end
      end
    end
  end

  // Read row selection, with optional same-set write forwarding; a read
  // during the sweep reports an empty set regardless of sweep progress.
  always_comb begin
    rd_row_p0 = vbits[rd_set];
`ifdef ICACHE_VALID_BYPASS_EN
    if (wr_ok_p0 && (wr_set == rd_set)) begin
      rd_row_p0[wr_way] = wr_val;
    end
`endif
    if (sweep_clr_p0) begin
      rd_row_p0 = '0;
    end
  end

  // Stage p1: registered read result; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld      <= 1'b0;
      rd_valid    <= '0;
      rd_free_vld <= 1'b0;
      rd_free_way <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_valid    <= rd_row_p0;
        rd_free_vld <= ~&rd_row_p0;
        rd_free_way <= first_free(rd_row_p0);
      end
    end
  end

  // Flash-invalidate FSM with registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush_done <= 1'b0;
          if (flush_req) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            flush_busy <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + SET_W'(1);
          if (sweep_cnt == SET_W'(NUM_SETS - 1)) begin
            state      <= DONE;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_valid_array.md
Name: icache_valid_array

Overview:
- Parametrised valid-bit store for the instruction cache: NUM_SETS x NUM_WAYS flops.
- Write path decodes (set, way) into a one-hot per-bit enable.
- Registered read returns the per-way valid vector plus the lowest-index free way, for refill victim choice.
- A flash-invalidate engine sweeps one set per cycle. Sits beside the icache tag array and is driven by the fill/flush controller.

Parameters:
- NUM_SETS, 64, number of sets; power of two, >=2.
- NUM_WAYS, 4, number of ways; power of two, >=2.
- SET_W, $clog2(NUM_SETS), set index width (localparam).
- WAY_W, $clog2(NUM_WAYS), way index width (localparam).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write one valid bit this cycle.
- wr_set  input  SET_W  set to write.
- wr_way  input  WAY_W  way to write.
- wr_val  input  1  value written (1 = set valid, 0 = invalidate).
- rd_en  input  1  read request.
- rd_set  input  SET_W  set to read.
- rd_vld  output  1  read data valid (one cycle after rd_en).
- rd_valid  output  NUM_WAYS  valid bits of the read set.
- rd_free_vld  output  1  at least one way of the read set is invalid.
- rd_free_way  output  WAY_W  lowest-index invalid way; 0 when rd_free_vld=0.
- flush_req  input  1  start flash invalidate (pulse or level).
- flush_busy  output  1  sweep in progress.
- flush_done  output  1  one-cycle pulse when sweep completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all array bits 0, FSM=IDLE, sweep counter 0.
- Reset outputs: rd_vld=0, rd_valid=0, rd_free_vld=0, rd_free_way=0, flush_busy=0, flush_done=0.
- rst mid-sweep aborts the sweep with no flush_done; the array is fully cleared anyway.
- Write:
  - In IDLE, wr_en updates bit [wr_set][wr_way] at the clock edge.
  - Only that bit may change (one-hot decode of wr_set x wr_way).
- Read:
  - 1-cycle latency. rd_en sampled at edge N gives rd_vld=1 at N+1 with the array contents before edge N's write.
  - rd_vld=0 whenever rd_en was 0; rd_valid, rd_free_* then hold their last value.
  - rd_free_way is a priority encode of ~rd_valid, lowest index first.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on flush_req; counter <= 0.
  - SWEEP: each cycle clears all ways of set[counter], counter++. At counter==NUM_SETS-1 the last set is cleared, then -> DONE. Counter wraps to 0.
  - DONE: flush_done=1 for exactly one cycle, then -> IDLE.
- flush_busy=1 in SWEEP only, for exactly NUM_SETS cycles.
- Same-cycle wr_en and flush_req in IDLE: the write commits, then the sweep clears it.
- wr_en in SWEEP or DONE is dropped silently; the array is unchanged.
- rd_en in SWEEP is accepted; it returns rd_valid=0 and rd_free_vld=1, rd_free_way=0 regardless of sweep progress.
- flush_req in SWEEP or DONE is ignored (no restart, no queueing).
- Write and read to different sets in the same cycle are independent.

Optional Feature:
- Macro ICACHE_VALID_BYPASS_EN.
- Defined: a read and a write to the same set at the same edge in IDLE return the post-write vector. rd_valid and rd_free_* reflect wr_val at wr_way.
- Undefined: the same-set read returns the pre-write vector (read-before-write). Other behaviour is identical.

Test Plan:
- Reset then rd_en, rd_set=5 -> next cycle rd_vld=1, rd_valid=4'b0000, rd_free_vld=1, rd_free_way=0.
- Writes of (set 3, way 0, 1), (set 3, way 1, 1), (set 3, way 3, 1), then read set 3 -> rd_valid=4'b1011, rd_free_way=2. Set 3 way 2 also written to 1 -> rd_valid=4'b1111, rd_free_vld=0, rd_free_way=0.
- Same-edge wr (set 7, way 2, 1) and rd set 7 from empty:
  - without macro -> rd_valid=4'b0000, rd_free_way=0;
  - with ICACHE_VALID_BYPASS_EN -> rd_valid=4'b0100, rd_free_way=0.
- Fill all sets, then pulse flush_req:
  - flush_busy high exactly 64 cycles, then flush_done one pulse;
  - wr_en at sweep cycle 10 (set 60, way 1, 1) is dropped;
  - a read of set 0 and a read of set 63 after done each give 4'b0000.
- Second flush_req during SWEEP -> no extension; flush_done fires once, 64 cycles after the first start.
- rst asserted at sweep cycle 20 -> next cycle flush_busy=0, no flush_done ever; all reads return 4'b0000; a fresh flush_req afterwards sweeps a full 64 cycles.
